// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition-code register, branch/cmov condition and M pipeline register.
// Define EXECUTE_CC_PORT_EN to expose the registered CC on cc_out for observation.
module execute_stage #(
    parameter int unsigned WORD = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      E_stat,
    input  logic [3:0]      E_icode,
    input  logic [3:0]      E_ifun,
    input  logic [WORD-1:0] E_valC,
    input  logic [WORD-1:0] E_valA,
    input  logic [WORD-1:0] E_valB,
    input  logic [3:0]      E_dstE,
    input  logic [3:0]      E_dstM,
    input  logic            M_bubble,
    input  logic [3:0]      m_stat,
    input  logic [3:0]      W_stat,
    output logic [WORD-1:0] e_valE,
    output logic [3:0]      e_dstE,
    output logic            e_Cnd,
    output logic [3:0]      M_stat,
    output logic [3:0]      M_icode,
    output logic            M_Cnd,
    output logic [WORD-1:0] M_valE,
    output logic [WORD-1:0] M_valA,
    output logic [3:0]      M_dstE,
    output logic [3:0]      M_dstM
`ifdef EXECUTE_CC_PORT_EN
    ,
    output logic [2:0]      cc_out
`endif
);

    localparam logic [3:0] StatAok = 4'b1000;
    localparam logic [3:0] StatHlt = 4'b0100;
    localparam logic [3:0] StatAdr = 4'b0010;
    localparam logic [3:0] StatIns = 4'b0001;
    localparam logic [3:0] RegNone = 4'hF;
    localparam logic [3:0] INop    = 4'h1;

    localparam logic [WORD-1:0] PlusEight  = WORD'(8);
    localparam logic [WORD-1:0] MinusEight = ~WORD'(7);

    logic [WORD-1:0] alu_a, alu_b, alu_t;
    logic [3:0]      alu_fun;
    logic            zf_new, sf_new, of_new;
    logic            set_cc;
    logic [2:0]      cc_q;  // {ZF, SF, OF}
    logic            zf, sf, of;

    always_comb begin
        alu_a = '0;
        unique case (E_icode)
            4'h2, 4'h6:       alu_a = E_valA;
            4'h3, 4'h4, 4'h5: alu_a = E_valC;
            4'h8, 4'hA:       alu_a = MinusEight;
            4'h9, 4'hB:       alu_a = PlusEight;
            default:          alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        unique case (E_icode)
            4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: alu_b = E_valB;
            default:                                  alu_b = '0;
        endcase
    end

    assign alu_fun = (E_icode == 4'h6) ? E_ifun : 4'h0;

    always_comb begin
        alu_t  = '0;
        of_new = 1'b0;
        unique case (alu_fun)
            4'h0: begin
                alu_t  = alu_b + alu_a;
                of_new = (alu_a[WORD-1] == alu_b[WORD-1]) && (alu_t[WORD-1] != alu_a[WORD-1]);
            end
            4'h1: begin
                alu_t  = alu_b - alu_a;
                of_new = (alu_a[WORD-1] != alu_b[WORD-1]) && (alu_t[WORD-1] != alu_b[WORD-1]);
            end
            4'h2:    alu_t = alu_b & alu_a;
            4'h3:    alu_t = alu_b ^ alu_a;
            // Undefined OPq functions yield zero but still load the flags.
            default: alu_t = '0;
        endcase
    end

    assign zf_new = (alu_t == '0);
    assign sf_new = alu_t[WORD-1];
    assign e_valE = alu_t;

    // Suppress the flag update when an older instruction downstream has faulted.
    assign set_cc = (E_icode == 4'h6) && (E_stat == StatAok)
                  && !(m_stat inside {StatHlt, StatAdr, StatIns})
                  && !(W_stat inside {StatHlt, StatAdr, StatIns});

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q <= 3'b100;
        end else if (set_cc) begin
            cc_q <= {zf_new, sf_new, of_new};
        end
    end

    assign {zf, sf, of} = cc_q;

    always_comb begin
        e_Cnd = 1'b0;
        unique case (E_ifun)
            4'h0:    e_Cnd = 1'b1;
            4'h1:    e_Cnd = (sf ^ of) | zf;
            4'h2:    e_Cnd = sf ^ of;
            4'h3:    e_Cnd = zf;
            4'h4:    e_Cnd = !zf;
            4'h5:    e_Cnd = !(sf ^ of);
            4'h6:    e_Cnd = !(sf ^ of) && !zf;
            default: e_Cnd = 1'b0;
        endcase
    end

    assign e_dstE = (E_icode == 4'h2 && !e_Cnd) ? RegNone : E_dstE;

    always_ff @(posedge clk) begin
        if (rst || M_bubble) begin
            M_stat  <= StatAok;
            M_icode <= INop;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RegNone;
            M_dstM  <= RegNone;
        end else begin
            M_stat  <= E_stat;
            M_icode <= E_icode;
            M_Cnd   <= e_Cnd;
            M_valE  <= e_valE;
            M_valA  <= E_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= E_dstM;
        end
    end

`ifdef EXECUTE_CC_PORT_EN
    assign cc_out = cc_q;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed literal checks plus randomized traffic
// compared every cycle against an instruction-level reference model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, m_stat, W_stat;
    logic [63:0] E_valC, E_valA, E_valB;
    logic        M_bubble;
    logic [63:0] e_valE, M_valE, M_valA;
    logic [3:0]  e_dstE, M_stat, M_icode, M_dstE, M_dstM;
    logic        e_Cnd, M_Cnd;
`ifdef EXECUTE_CC_PORT_EN
    logic [2:0]  cc_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    execute_stage #(.WORD(64)) dut (
        .clk(clk), .rst(rst),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .M_bubble(M_bubble), .m_stat(m_stat), .W_stat(W_stat),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
`ifdef EXECUTE_CC_PORT_EN
        , .cc_out(cc_out)
`endif
    );

    // Reference model state: condition codes and the expected M register contents.
    logic        mzf, msf, mof;
    logic [3:0]  x_stat, x_icode, x_dstE, x_dstM;
    logic        x_cnd;
    logic [63:0] x_valE, x_valA;

    typedef struct packed {
        logic [63:0] val;
        logic        zf, sf, of;
    } alu_res_t;

    // Result of the instruction as a whole, written per instruction class.
    function automatic alu_res_t model_exec(input logic [3:0] icode, input logic [3:0] ifun,
                                            input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] c);
        alu_res_t   r;
        logic [64:0] wide;
        r = '0;
        case (icode)
            4'h2:       r.val = a;
            4'h3:       r.val = c;
            4'h4, 4'h5: r.val = b + c;
            4'h8, 4'hA: r.val = b - 64'd8;
            4'h9, 4'hB: r.val = b + 64'd8;
            4'h6: begin
                case (ifun)
                    4'h0: begin
                        wide  = {b[63], b} + {a[63], a};
                        r.val = wide[63:0];
                        r.of  = wide[64] != wide[63];
                    end
                    4'h1: begin
                        wide  = {b[63], b} - {a[63], a};
                        r.val = wide[63:0];
                        r.of  = wide[64] != wide[63];
                    end
                    4'h2:    r.val = a & b;
                    4'h3:    r.val = a ^ b;
                    default: r.val = 64'd0;
                endcase
            end
            default: r.val = 64'd0;
        endcase
        r.zf = (r.val == 64'd0);
        r.sf = r.val[63];
        return r;
    endfunction

    function automatic logic model_cond(input logic [3:0] ifun, input logic zf,
                                        input logic sf, input logic of);
        case (ifun)
            4'h0:    return 1'b1;
            4'h1:    return (sf != of) || zf;
            4'h2:    return sf != of;
            4'h3:    return zf;
            4'h4:    return !zf;
            4'h5:    return sf == of;
            4'h6:    return (sf == of) && !zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic faulted(input logic [3:0] s);
        return (s == 4'b0100) || (s == 4'b0010) || (s == 4'b0001);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        {mzf, msf, mof} = 3'b100;
        x_stat = 4'b1000; x_icode = 4'h1; x_cnd = 1'b0;
        x_valE = '0; x_valA = '0; x_dstE = 4'hF; x_dstM = 4'hF;
    endtask

    task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                         input logic [3:0] de, input logic [3:0] dm);
        rst = 1'b0; M_bubble = 1'b0;
        E_stat = 4'b1000; m_stat = 4'b1000; W_stat = 4'b1000;
        E_icode = icode; E_ifun = ifun; E_valA = va; E_valB = vb; E_valC = vc;
        E_dstE = de; E_dstM = dm;
    endtask

    // Compare process: called once per cycle with inputs settled, checks then advances model.
    task automatic cycle();
        alu_res_t   r;
        logic       cnd, set;
        logic [3:0] de;
        #1;
        r   = model_exec(E_icode, E_ifun, E_valA, E_valB, E_valC);
        cnd = model_cond(E_ifun, mzf, msf, mof);
        de  = (E_icode == 4'h2 && !cnd) ? 4'hF : E_dstE;
        check("e_valE", e_valE, r.val);
        check("e_dstE", {60'd0, e_dstE}, {60'd0, de});
        check("e_Cnd", {63'd0, e_Cnd}, {63'd0, cnd});
        check("M_stat", {60'd0, M_stat}, {60'd0, x_stat});
        check("M_icode", {60'd0, M_icode}, {60'd0, x_icode});
        check("M_Cnd", {63'd0, M_Cnd}, {63'd0, x_cnd});
        check("M_valE", M_valE, x_valE);
        check("M_valA", M_valA, x_valA);
        check("M_dstE", {60'd0, M_dstE}, {60'd0, x_dstE});
        check("M_dstM", {60'd0, M_dstM}, {60'd0, x_dstM});
`ifdef EXECUTE_CC_PORT_EN
        check("cc_out", {61'd0, cc_out}, {61'd0, mzf, msf, mof});
`endif
        set = (E_icode == 4'h6) && (E_stat == 4'b1000) && !faulted(m_stat) && !faulted(W_stat);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (set) {mzf, msf, mof} = {r.zf, r.sf, r.of};
            if (M_bubble) begin
                x_stat = 4'b1000; x_icode = 4'h1; x_cnd = 1'b0;
                x_valE = '0; x_valA = '0; x_dstE = 4'hF; x_dstM = 4'hF;
            end else begin
                x_stat = E_stat; x_icode = E_icode; x_cnd = cnd;
                x_valE = r.val; x_valA = E_valA; x_dstE = de; x_dstM = E_dstM;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [63:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return 64'h7FFF_FFFF_FFFF_FFFF;
            3:       return 64'h8000_0000_0000_0000;
            4:       return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [3:0] rand_stat();
        logic [3:0] s;
        s = 4'b1000;
        if ($urandom_range(0, 5) == 0) s = 4'b0001 << $urandom_range(0, 3);
        return s;
    endfunction

    initial begin
        drive(4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF);
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);

        // Reset state, then je on reset CC.
        drive(4'h7, 4'h3, '0, '0, '0, 4'hF, 4'hF);
        #1;
        check("rst_M_icode", {60'd0, M_icode}, 64'd1);
        check("rst_M_dstE", {60'd0, M_dstE}, 64'hF);
        check("rst_M_stat", {60'd0, M_stat}, 64'h8);
        check("rst_je", {63'd0, e_Cnd}, 64'd1);
        cycle();

        drive(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, '0, 4'h2, 4'hF);
        #1; check("addq_ovf", e_valE, 64'h8000_0000_0000_0000);
        cycle();
        drive(4'h7, 4'h2, '0, '0, '0, 4'hF, 4'hF);
        #1; check("jl_after_ovf", {63'd0, e_Cnd}, 64'd0);
`ifdef EXECUTE_CC_PORT_EN
        check("cc_after_ovf", {61'd0, cc_out}, 64'b011);
`endif
        cycle();
        drive(4'h7, 4'h5, '0, '0, '0, 4'hF, 4'hF);
        #1; check("jge_after_ovf", {63'd0, e_Cnd}, 64'd1);
        cycle();

        drive(4'h6, 4'h1, 64'd5, 64'd5, '0, 4'h2, 4'hF);
        #1; check("subq_zero", e_valE, 64'd0);
        cycle();
        drive(4'h2, 4'h4, 64'h55, '0, '0, 4'h3, 4'hF);
        #1; check("cmovne_dst", {60'd0, e_dstE}, 64'hF);
        cycle();
        drive(4'h2, 4'h3, 64'h55, '0, '0, 4'h3, 4'hF);
        #1;
        check("cmovne_M_Cnd", {63'd0, M_Cnd}, 64'd0);
        check("cmove_dst", {60'd0, e_dstE}, 64'h3);
        cycle();

        drive(4'hA, 4'h0, '0, 64'h100, '0, 4'h4, 4'hF);
        #1; check("pushq", e_valE, 64'hF8);
        cycle();
        drive(4'h8, 4'h0, '0, 64'h100, '0, 4'h4, 4'hF);
        #1; check("call", e_valE, 64'hF8);
        cycle();
        drive(4'hB, 4'h0, '0, 64'h100, '0, 4'h4, 4'h6);
        #1; check("popq", e_valE, 64'h108);
        cycle();

        // OPq suppressed by a faulted instruction in M; CC stays ZF=1.
        drive(4'h6, 4'h0, 64'd1, 64'd1, '0, 4'h2, 4'hF);
        m_stat = 4'b0010;
        #1; check("popq_M_dstM", {60'd0, M_dstM}, 64'h6);
        cycle();
        drive(4'h7, 4'h3, '0, '0, '0, 4'hF, 4'hF);
        #1; check("je_cc_held", {63'd0, e_Cnd}, 64'd1);
        cycle();
        // OPq with bubble: flags still load (1 - 2 = -1, SF=1).
        drive(4'h6, 4'h1, 64'd2, 64'd1, '0, 4'h2, 4'hF);
        M_bubble = 1'b1;
        cycle();
        drive(4'h7, 4'h2, '0, '0, '0, 4'hF, 4'hF);
        #1;
        check("bubble_M_icode", {60'd0, M_icode}, 64'd1);
        check("bubble_M_dstE", {60'd0, M_dstE}, 64'hF);
        check("jl_after_bubble", {63'd0, e_Cnd}, 64'd1);
        cycle();

        drive(4'h5, 4'h0, '0, 64'h10, 64'h20, 4'hF, 4'h3);
        cycle();
        drive(4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF);
        #1; check("mrmovq_M_valE", M_valE, 64'h30);
        cycle();

        for (int i = 0; i < 2000; i++) begin
            rst      = ($urandom_range(0, 40) == 0);
            M_bubble = ($urandom_range(0, 7) == 0);
            E_stat   = rand_stat();
            m_stat   = rand_stat();
            W_stat   = rand_stat();
            E_icode  = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
            E_ifun   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(0, 6));
            E_valA   = rand_word();
            E_valB   = rand_word();
            E_valC   = rand_word();
            E_dstE   = 4'($urandom_range(0, 15));
            E_dstM   = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
